// File: rtl/cache_group_ctrl_if.sv
// Signal bundle for one cache group: CPU request port,
// per-way line storage port and word-serial memory burst port.
interface cache_group_ctrl_if #(
    parameter int CACHE_LINE_WIDTH = 6,
    parameter int INDEX_WIDTH      = 6,
    parameter int TAG_WIDTH        = 20
);
    localparam int OFF = CACHE_LINE_WIDTH - 2;

    logic                     cpu_req;
    logic                     cpu_we;
    logic [31:0]              cpu_addr;
    logic [31:0]              cpu_wdata;
    logic [3:0]               cpu_be;
    logic                     cpu_ack;
    logic [31:0]              cpu_rdata;

    logic [INDEX_WIDTH-1:0]   line_index;
    logic [OFF-1:0]           line_rd_off;
    logic [2*TAG_WIDTH-1:0]   line_rd_tag;
    logic [63:0]              line_rd_data;
    logic [1:0]               line_rd_valid;
    logic [1:0]               line_rd_dirty;
    logic [1:0]               line_wr_write;
    logic [TAG_WIDTH-1:0]     line_wr_tag;
    logic [OFF-1:0]           line_wr_off;
    logic [31:0]              line_wr_data;
    logic [3:0]               line_wr_byte_enable;
    logic                     line_wr_dirty;
    logic                     line_wr_valid;

    logic                     mem_req;
    logic                     mem_we;
    logic [31:0]              mem_addr;
    logic [31:0]              mem_wdata;
    logic                     mem_wvalid;
    logic                     mem_wready;
    logic [31:0]              mem_rdata;
    logic                     mem_rvalid;

    // Environment side: CPU, line storage and memory bridge.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        input  cpu_ack, cpu_rdata,
        input  line_index, line_rd_off,
        output line_rd_tag, line_rd_data, line_rd_valid, line_rd_dirty,
        input  line_wr_write, line_wr_tag, line_wr_off, line_wr_data,
        input  line_wr_byte_enable, line_wr_dirty, line_wr_valid,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wvalid,
        output mem_wready, mem_rdata, mem_rvalid
    );

    // Controller side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        output cpu_ack, cpu_rdata,
        output line_index, line_rd_off,
        input  line_rd_tag, line_rd_data, line_rd_valid, line_rd_dirty,
        output line_wr_write, line_wr_tag, line_wr_off, line_wr_data,
        output line_wr_byte_enable, line_wr_dirty, line_wr_valid,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wvalid,
        input  mem_wready, mem_rdata, mem_rvalid
    );
endinterface

// File: rtl/cache_group_ctrl.sv
// 2-way set-associative cache group sequencer: lookup, write-hit merge,
// LRU victim choice, dirty write-back burst and refill burst.
module cache_group_ctrl #(
    parameter int CACHE_LINE_WIDTH = 6,
    parameter int INDEX_WIDTH      = 6,
    parameter int TAG_WIDTH        = 20
) (
    input  logic              clk,
    input  logic              rst,
    cache_group_ctrl_if.slave bus
);
    localparam int OFF  = CACHE_LINE_WIDTH - 2;
    localparam int SETS = 2 ** INDEX_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        WB,
        REFILL
    } state_t;

    state_t              state_q, state_d;
    logic [OFF-1:0]      cnt_q, cnt_d;
    logic [SETS-1:0]     lru_q, lru_d;
    logic [31:0]         addr_q, addr_d;
    logic                we_q, we_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          be_q, be_d;
    logic                victim_q, victim_d;

    logic [TAG_WIDTH-1:0]   tag_q;
    logic [INDEX_WIDTH-1:0] idx_q;
    logic [OFF-1:0]         off_q;
    logic [TAG_WIDTH-1:0]   way_tag [2];
    logic [31:0]            way_data [2];
    logic [1:0]             hit;
    logic                   hit_way;
    logic                   vict;
    logic                   last_word;

    assign tag_q = addr_q[31 -: TAG_WIDTH];
    assign idx_q = addr_q[CACHE_LINE_WIDTH +: INDEX_WIDTH];
    assign off_q = addr_q[2 +: OFF];

    assign way_tag[0]  = bus.line_rd_tag[TAG_WIDTH-1:0];
    assign way_tag[1]  = bus.line_rd_tag[2*TAG_WIDTH-1:TAG_WIDTH];
    assign way_data[0] = bus.line_rd_data[31:0];
    assign way_data[1] = bus.line_rd_data[63:32];

    assign hit[0]  = bus.line_rd_valid[0] && (way_tag[0] == tag_q);
    assign hit[1]  = bus.line_rd_valid[1] && (way_tag[1] == tag_q);
    assign hit_way = !hit[0];

    // Invalid ways are filled first (way0 preferred) before LRU applies.
    assign vict = !bus.line_rd_valid[0] ? 1'b0 :
                  !bus.line_rd_valid[1] ? 1'b1 : lru_q[idx_q];

    assign last_word = &cnt_q;

    assign bus.line_index  = idx_q;
    assign bus.line_rd_off = (state_q == WB) ? cnt_q : off_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            lru_q    <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '0;
            victim_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lru_q    <= lru_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            victim_q <= victim_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lru_d    = lru_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        victim_d = victim_q;

        bus.cpu_ack             = 1'b0;
        bus.cpu_rdata           = '0;
        bus.line_wr_write       = 2'b00;
        bus.line_wr_tag         = tag_q;
        bus.line_wr_off         = off_q;
        bus.line_wr_data        = wdata_q;
        bus.line_wr_byte_enable = be_q;
        bus.line_wr_dirty       = 1'b0;
        bus.line_wr_valid       = 1'b0;
        bus.mem_req             = 1'b0;
        bus.mem_we              = 1'b0;
        bus.mem_addr            = '0;
        bus.mem_wdata           = '0;
        bus.mem_wvalid          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.cpu_req) begin
                    addr_d  = bus.cpu_addr;
                    we_d    = bus.cpu_we;
                    wdata_d = bus.cpu_wdata;
                    be_d    = bus.cpu_be;
                    state_d = LOOKUP;
                end
            end

            LOOKUP: begin
                if (|hit) begin
                    bus.cpu_ack   = 1'b1;
                    lru_d[idx_q]  = ~hit_way;
                    state_d       = IDLE;
                    if (we_q) begin
                        bus.line_wr_write = hit_way ? 2'b10 : 2'b01;
                        bus.line_wr_dirty = 1'b1;
                        bus.line_wr_valid = 1'b1;
                    end else begin
                        bus.cpu_rdata = way_data[hit_way];
                    end
                end else begin
                    victim_d = vict;
                    cnt_d    = '0;
                    if (bus.line_rd_valid[vict] && bus.line_rd_dirty[vict]) begin
                        state_d = WB;
                    end else begin
                        state_d = REFILL;
                    end
                end
            end

            WB: begin
                bus.mem_req    = 1'b1;
                bus.mem_we     = 1'b1;
                bus.mem_addr   = {way_tag[victim_q], idx_q,
                                  {CACHE_LINE_WIDTH{1'b0}}};
                bus.mem_wvalid = 1'b1;
                bus.mem_wdata  = way_data[victim_q];
                if (bus.mem_wready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_word) begin
                        state_d = REFILL;
                    end
                end
            end

            REFILL: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {tag_q, idx_q, {CACHE_LINE_WIDTH{1'b0}}};
                if (bus.mem_rvalid) begin
                    // The line only turns valid once its final word lands.
                    bus.line_wr_write       = victim_q ? 2'b10 : 2'b01;
                    bus.line_wr_off         = cnt_q;
                    bus.line_wr_data        = bus.mem_rdata;
                    bus.line_wr_byte_enable = 4'hF;
                    bus.line_wr_valid       = last_word;
                    cnt_d                   = cnt_q + 1'b1;
                    if (last_word) begin
                        state_d = LOOKUP;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_cache_group_ctrl.sv
// Directed bench for cache_group_ctrl with line-storage and memory models
// and an expected-response queue.
module tb_cache_group_ctrl;
    localparam int WORDS = 16;

    typedef struct {
        logic        we;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    logic clk;
    logic rst_n;

    cache_group_ctrl_if bus ();

    cache_group_ctrl dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-way line storage, read combinationally, written on the clock.
    logic [19:0] s_tag [2][64] = '{default: '0};
    logic        s_val [2][64] = '{default: '0};
    logic        s_dty [2][64] = '{default: '0};
    logic [31:0] s_dat [2][64][16] = '{default: '0};

    assign bus.line_rd_tag   = {s_tag[1][bus.line_index], s_tag[0][bus.line_index]};
    assign bus.line_rd_valid = {s_val[1][bus.line_index], s_val[0][bus.line_index]};
    assign bus.line_rd_dirty = {s_dty[1][bus.line_index], s_dty[0][bus.line_index]};
    assign bus.line_rd_data  = {s_dat[1][bus.line_index][bus.line_rd_off],
                                s_dat[0][bus.line_index][bus.line_rd_off]};

    always @(posedge clk) begin
        for (int w = 0; w < 2; w++) begin
            if (bus.line_wr_write[w]) begin
                s_tag[w][bus.line_index] <= bus.line_wr_tag;
                s_val[w][bus.line_index] <= bus.line_wr_valid;
                s_dty[w][bus.line_index] <= bus.line_wr_dirty;
                for (int b = 0; b < 4; b++) begin
                    if (bus.line_wr_byte_enable[b]) begin
                        s_dat[w][bus.line_index][bus.line_wr_off][8*b +: 8]
                            <= bus.line_wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int acks = 0;
    int reqs = 0;
    int last_ack = 0;
    int prev_ack = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.cpu_ack) acks <= acks + 1;
    end

    exp_t sb [$];
    logic [31:0] ref_m [logic [29:0]];
    logic [31:0] bmem  [logic [29:0]];

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'hA5C3_0000 ^ (a * 32'h0001_0001);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_m.exists(a[31:2])) return ref_m[a[31:2]];
        return pat({a[31:2], 2'b00});
    endfunction

    function automatic logic [31:0] bm_rd(input logic [31:0] a);
        if (bmem.exists(a[31:2])) return bmem[a[31:2]];
        return pat({a[31:2], 2'b00});
    endfunction

    task automatic ref_wr(input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be);
        logic [31:0] m;
        m = ref_rd(a);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) m[8*b +: 8] = wd[8*b +: 8];
        end
        ref_m[a[31:2]] = m;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk(tag, {23'h0, bus.cpu_ack, bus.mem_req, bus.mem_we,
                  bus.mem_wvalid, bus.line_wr_write, bus.cpu_rdata},
            64'h0);
        chk({tag, "_addr"}, {26'h0, bus.line_index, bus.mem_addr}, 64'h0);
    endtask

    // One CPU transaction; services the memory port until cpu_ack.
    task automatic access(input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          input int lat, input logic [1:0] way,
                          input bit wb, input logic [31:0] wbb,
                          input bit tog, input int rst_beat);
        exp_t e;
        int n, rb, wc, st;
        bit got, wlast, aborted;
        logic [31:0] lb;
        @(negedge clk);
        e.we    = we;
        e.rdata = we ? 32'h0 : ref_rd(a);
        e.lat   = lat;
        sb.push_back(e);
        if (we) ref_wr(a, wd, be);
        lb = {a[31:6], 6'b0};
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = wd;
        bus.cpu_be    = be;
        bus.cpu_req   = 1'b1;
        reqs++;
        n = 0; rb = 0; wc = 0; st = 0;
        got = 0; wlast = 0; aborted = 0;
        while (!got && !aborted && n < 400) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            bus.mem_wready = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = '0;
            if (tog) bus.cpu_req = bus.mem_req ? n[0] : 1'b1;
            if (wlast) begin
                chk("wb_to_refill", 64'({bus.mem_req, bus.mem_we}), 64'h2);
                wlast = 0;
            end
            if (bus.cpu_ack) begin
                got = 1;
                e = sb.pop_front();
                chk("ack_latency", 64'(n), 64'(e.lat));
                if (e.we) begin
                    chk("wr_strobe", 64'(bus.line_wr_write), 64'(way));
                    chk("wr_ctl", 64'({bus.line_wr_dirty, bus.line_wr_valid,
                                       bus.line_wr_byte_enable}),
                        64'({2'b11, be}));
                    chk("wr_data", 64'(bus.line_wr_data), 64'(wd));
                end else begin
                    chk("rdata", 64'(bus.cpu_rdata), 64'(e.rdata));
                end
                prev_ack = last_ack;
                last_ack = cyc;
                bus.cpu_req = 1'b0;
            end else if (bus.mem_req && bus.mem_we) begin
                if (wc == 0 && st == 0) chk("wb_addr", 64'(bus.mem_addr), 64'(wbb));
                chk("wb_word", 64'({bus.mem_wvalid, bus.mem_wdata}),
                    64'({1'b1, ref_rd(wbb + 32'(wc * 4))}));
                if (wc == 7 && st < 5) begin
                    st++;
                end else begin
                    bus.mem_wready = 1'b1;
                    bmem[(wbb >> 2) + 30'(wc)] = bus.mem_wdata;
                    wc++;
                    if (wc == WORDS) wlast = 1;
                end
            end else if (bus.mem_req) begin
                if (rb == 0) chk("rf_addr", 64'(bus.mem_addr), 64'(lb));
                if (rb == rst_beat) begin
                    rst_n = 1'b0;
                    #1;
                    chk_idle_outputs("rst_mid_refill");
                    aborted = 1;
                    e = sb.pop_back();
                    reqs--;
                end else begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = bm_rd(lb + 32'(rb * 4));
                    #1;
                    if (rb == 0) chk("rf_strobe", 64'(bus.line_wr_write), 64'(way));
                    if (rb == WORDS - 1) begin
                        chk("rf_last_ctl", 64'({bus.line_wr_valid, bus.line_wr_dirty,
                                                bus.line_wr_byte_enable}),
                            64'h2F);
                    end
                    rb++;
                end
            end
        end
        if (aborted) begin
            bus.cpu_req = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            if (!got) chk("ack_timeout", 64'(got), 64'h1);
            if (lat > 1) chk("refill_beats", 64'(rb), 64'(WORDS));
            if (wb) chk("wb_words", 64'(wc), 64'(WORDS));
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.cpu_req    = 1'b0;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = '0;
        bus.cpu_wdata  = '0;
        bus.cpu_be     = '0;
        bus.mem_wready = 1'b0;
        bus.mem_rdata  = '0;
        bus.mem_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;

        // Cold miss into way0, then write-merge and back-to-back hits.
        access(0, 32'h0000_1004, 0, 0, 18, 2'b01, 0, 0, 0, -1);
        access(1, 32'h0000_1008, 32'hAABB_CCDD, 4'b0011, 1, 2'b01, 0, 0, 0, -1);
        access(0, 32'h0000_1008, 0, 0, 1, 2'b00, 0, 0, 0, -1);
        chk("b2b_spacing", 64'(last_ack - prev_ack), 64'h2);

        // Way1 fill, then LRU evicts dirty way0 with a stalled write-back.
        access(0, 32'h0000_2000, 0, 0, 18, 2'b10, 0, 0, 0, -1);
        access(0, 32'h0000_3004, 0, 0, 39, 2'b01, 1, 32'h0000_1000, 1, -1);

        // Written-back line comes back from memory into LRU way1.
        access(0, 32'h0000_1008, 0, 0, 18, 2'b10, 0, 0, 0, -1);

        // Set 1: both ways valid and LRU pointing at way1.
        access(0, 32'h0000_1040, 0, 0, 18, 2'b01, 0, 0, 0, -1);
        access(0, 32'h0000_2040, 0, 0, 18, 2'b10, 0, 0, 0, -1);
        access(0, 32'h0000_1044, 0, 0, 1, 2'b00, 0, 0, 0, -1);

        // Reset during a refill, then LRU must be back to way0.
        access(0, 32'h0000_4000, 0, 0, 18, 2'b01, 0, 0, 0, 9);
        access(0, 32'h0000_3040, 0, 0, 18, 2'b01, 0, 0, 0, -1);
        access(0, 32'h0000_4008, 0, 0, 18, 2'b01, 0, 0, 0, -1);

        repeat (3) @(negedge clk);
        chk("ack_count", 64'(acks), 64'(reqs));
        chk("sb_empty", 64'(sb.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cache_group_ctrl.md
Name: cache_group_ctrl

Overview:
- Sequences one 2-way set-associative cache group built from two cacheline storage blocks, one per way.
- Performs hit lookup, write-hit byte merge, LRU victim selection, dirty write-back burst and refill burst over a simple word-serial memory port.
- Sits between the CPU-side request port and the AXI bridge; the set index is exported to the line storage.

Parameters:
CACHE_LINE_WIDTH, 6, log2 bytes per line; OFF = CACHE_LINE_WIDTH-2 word-offset bits, WORDS = 2**OFF
INDEX_WIDTH, 6, log2 number of sets; one LRU bit per set
TAG_WIDTH, 20, must equal 32-INDEX_WIDTH-CACHE_LINE_WIDTH

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
cpu_req  in  1  request, held stable until cpu_ack
cpu_we  in  1  1 = write
cpu_addr  in  32  byte address {tag,index,off,2'b00}
cpu_wdata  in  32  write data
cpu_be  in  4  byte enables for write
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  32  read data, valid with cpu_ack
line_index  out  INDEX_WIDTH  set selected in both ways
line_rd_off  out  OFF  word offset read from both ways
line_rd_tag  in  2*TAG_WIDTH  way1 in upper half
line_rd_data  in  64  way1 in [63:32]
line_rd_valid  in  2  per-way valid
line_rd_dirty  in  2  per-way dirty
line_wr_write  out  2  per-way write strobe, at most one high
line_wr_tag  out  TAG_WIDTH  tag to write
line_wr_off  out  OFF  word offset to write
line_wr_data  out  32  data to write
line_wr_byte_enable  out  4  byte enables to write
line_wr_dirty  out  1  dirty to write
line_wr_valid  out  1  valid to write
mem_req  out  1  burst active
mem_we  out  1  1 = write-back burst
mem_addr  out  32  line-aligned burst base address
mem_wdata  out  32  write-back word
mem_wvalid  out  1  write word valid
mem_wready  in  1  write word accepted
mem_rdata  in  32  refill word
mem_rvalid  in  1  refill word valid

Behaviour:
- Reset: state IDLE; word counter 0; all LRU bits 0; cpu_ack, mem_req, mem_we, mem_wvalid and line_wr_write all 0; cpu_rdata 0. Reset mid-burst abandons the burst with no further line writes.
- States: IDLE, LOOKUP, WB, REFILL.
- IDLE: if cpu_req, latch addr/we/wdata/be and go to LOOKUP. Requests arriving while not in IDLE are not sampled.
- line_index is the latched index. line_rd_off is the latched offset in LOOKUP and the counter in WB.
- LOOKUP hit: hit[w] = valid[w] && tag[w]==latched tag.
  - Read hit: cpu_ack=1 and cpu_rdata = hit way's data, same cycle. LRU[index] <= other way. Go to IDLE.
  - Write hit: line_wr_write[w]=1 with tag unchanged, off, wdata, be, dirty=1, valid=1. cpu_ack=1, LRU update as for a read hit, go to IDLE.
  - Hit latency is 2 cycles from req; back-to-back hits complete every 2 cycles.
- LOOKUP miss, victim selection: first invalid way, with way0 preferred; else LRU[index]. Victim is latched.
  - Victim valid and dirty: go to WB.
  - Otherwise: go to REFILL.
  - Counter is cleared in either case.
- WB: mem_req=1, mem_we=1, mem_addr={victim tag,index,0}, mem_wvalid=1, mem_wdata = victim way's data at counter.
  - Counter increments on mem_wvalid && mem_wready.
  - Handshake on word WORDS-1: go to REFILL, counter 0.
- REFILL: mem_req=1, mem_we=0, mem_addr={latched tag,index,0}.
  - Each mem_rvalid writes the victim way: off=counter, data=mem_rdata, be=4'hF, tag=latched tag, dirty=0. valid=0 except on word WORDS-1, where valid=1. Counter increments.
  - After the last word: mem_req drops next cycle and state returns to LOOKUP, which now hits (total miss = burst + 2 lookups).
- mem_req is continuous for the whole burst. A WB burst followed by a REFILL burst drops mem_req for no cycles, only mem_we changes.
- Counter wraps at WORDS; the offset width is OFF exactly.

Test Plan:
- Reset, then read 0x0000_1004 with both ways invalid -> REFILL into way0 (WORDS=16 beats, mem_addr 0x0000_1000), then cpu_ack with word 1 of refill data. LRU[index]=1.
- Write 0x0000_1008, wdata 0xAABBCCDD, be 4'b0011 on hit -> way0 write strobe, dirty=1. Subsequent read of 0x0000_1008 returns old[31:16] with 0xCCDD in the lower half, ack 2 cycles after req.
- Fill way1 with tag B, then access tag C in the same set -> LRU victim selected. If it is the dirty way0: WB of 16 words to 0x0000_1000 with the written word intact, then REFILL at tag C.
- During WB, hold mem_wready low for 5 cycles on word 7 -> mem_wdata and counter stable, no skipped or duplicated word.
- Assert rst low mid-REFILL at word 9 -> all outputs 0 immediately; next request restarts cleanly with LRU 0.
- Toggle cpu_req during a miss burst -> ignored; exactly one cpu_ack per accepted request.
